// File: rtl/tb_intc_pkg.sv
// rtl/tb_intc_pkg.sv - register offsets, bus widths and index-width helper for the interrupt controller
package tb_intc_pkg;

  localparam int DATA_W = 16;
  localparam int PORT_W = 16;

  localparam logic [2:0] OFS_STATUS  = 3'd0;
  localparam logic [2:0] OFS_MASK    = 3'd1;
  localparam logic [2:0] OFS_CLEAR   = 3'd2;
  localparam logic [2:0] OFS_VECTOR  = 3'd3;
  localparam logic [2:0] OFS_OVERRUN = 3'd4;
  localparam logic [PORT_W-1:0] NUM_REGS = 16'd5;

  // Never returns 0 so a single-source build still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tb_intc_prio_enc.sv
// rtl/tb_intc_prio_enc.sv - lowest-index-wins priority encoder, outputs {any, idx}
module tb_intc_prio_enc
  import tb_intc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tb_intc_io_ctrl.sv
// rtl/tb_intc_io_ctrl.sv - NUM_SRC-source interrupt controller on the 16-bit port bus
// Optional INTC_EDGE_DETECT_EN: events are rising edges of src_i instead of levels.
module tb_intc_io_ctrl
  import tb_intc_pkg::*;
#(
  parameter int               NUM_SRC   = 4,
  parameter logic [PORT_W-1:0] BASE_ADDR = 16'h0010,
  parameter logic [DATA_W-1:0] MASK_RST  = 16'hFFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [PORT_W-1:0]  port_id,
  input  logic [DATA_W-1:0]  out_port,
  input  logic               read_strobe,
  input  logic               write_strobe,
  input  logic               int_ack,
  output logic               irq_o,
  output logic [DATA_W-1:0]  rd_data_o
);

  localparam int IDX_W = clog2(NUM_SRC);

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]  vector_q, vector_d;
  logic               irq_q, irq_d;
  logic [NUM_SRC-1:0] event_s;

`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] src_q, src_d;

  always_comb src_d = src_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) src_q <= '0;
    else       src_q <= src_d;
  end

  assign event_s = src_i & ~src_q;
`else
  assign event_s = src_i;
`endif

  logic [PORT_W-1:0] offset;
  logic              hit;
  logic [2:0]        ofs;
  logic              wr_mask, wr_clear;

  // Wrapping subtraction makes any port_id below BASE_ADDR land far out of range.
  assign offset   = port_id - BASE_ADDR;
  assign hit      = (offset < NUM_REGS);
  assign ofs      = offset[2:0];
  assign wr_mask  = write_strobe && hit && (ofs == OFS_MASK);
  assign wr_clear = write_strobe && hit && (ofs == OFS_CLEAR);

  logic               win_any;
  logic [IDX_W-1:0]   win_idx;

  tb_intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req_i (pending_q & mask_q),
    .any_o (win_any),
    .idx_o (win_idx)
  );

  logic [NUM_SRC-1:0] sw_clr, ack_clr, all_clr;

  always_comb begin
    sw_clr  = wr_clear ? out_port[NUM_SRC-1:0] : '0;
    ack_clr = (int_ack && win_any) ? (NUM_SRC'(1) << win_idx) : '0;
    all_clr = sw_clr | ack_clr;

    // A same-edge event wins over any clear and suppresses the overrun flag.
    pending_d = (pending_q & ~all_clr) | event_s;
    overrun_d = (overrun_q & ~sw_clr) | (event_s & pending_q & ~all_clr);
    mask_d    = wr_mask ? out_port[NUM_SRC-1:0] : mask_q;

    vector_d = vector_q;
    if (int_ack) begin
      vector_d = win_any ? {1'b1, 11'b0, 4'(win_idx)} : '0;
    end

    irq_d = |(pending_d & mask_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= MASK_RST[NUM_SRC-1:0];
      vector_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      mask_q    <= mask_d;
      vector_q  <= vector_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    rd_data_o = '0;
    if (read_strobe && hit) begin
      case (ofs)
        OFS_STATUS:  rd_data_o = DATA_W'(pending_q);
        OFS_MASK:    rd_data_o = DATA_W'(mask_q);
        OFS_VECTOR:  rd_data_o = vector_q;
        OFS_OVERRUN: rd_data_o = DATA_W'(overrun_q);
        default:     rd_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_intc_io_ctrl.sv
// tb/tb_tb_intc_io_ctrl.sv - scoreboard bench for the interrupt controller
module tb_tb_intc_io_ctrl;

  localparam logic [15:0] BASE = 16'h0010;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  src_i = '0;
  logic [15:0] port_id = '0;
  logic [15:0] out_port = '0;
  logic        read_strobe = 1'b0;
  logic        write_strobe = 1'b0;
  logic        int_ack = 1'b0;
  logic        irq_o;
  logic [15:0] rd_data_o;

  logic        irq_chk = 1'b0;
  logic        done = 1'b0;

  logic [15:0] rd_exp_q[$];
  string       rd_nm_q[$];
  logic        irq_exp_q[$];
  string       irq_nm_q[$];

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] e_rd;
  logic        e_irq;
  string       nm;

  tb_intc_io_ctrl #(
    .NUM_SRC   (4),
    .BASE_ADDR (BASE),
    .MASK_RST  (16'hFFFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .src_i        (src_i),
    .port_id      (port_id),
    .out_port     (out_port),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .int_ack      (int_ack),
    .irq_o        (irq_o),
    .rd_data_o    (rd_data_o)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (read_strobe) begin
      n_chk++;
      if (rd_exp_q.size() == 0) begin
        $display("FAIL unexpected_read: got %h want none", rd_data_o);
      end else begin
        e_rd = rd_exp_q.pop_front();
        nm   = rd_nm_q.pop_front();
        if (rd_data_o === e_rd) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, rd_data_o, e_rd);
      end
    end
    if (irq_chk) begin
      n_chk++;
      if (irq_exp_q.size() == 0) begin
        $display("FAIL unexpected_irq_check: got %b want none", irq_o);
      end else begin
        e_irq = irq_exp_q.pop_front();
        nm    = irq_nm_q.pop_front();
        if (irq_o === e_irq) n_pass++;
        else $display("FAIL %s: got %b want %b", nm, irq_o, e_irq);
      end
    end
    if (done) begin
      n_chk++;
      if (rd_exp_q.size() == 0 && irq_exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d left want 0", rd_exp_q.size() + irq_exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    irq_chk = 1'b0;
  endtask

  task automatic exp_irq(input logic v, input string name);
    irq_exp_q.push_back(v);
    irq_nm_q.push_back(name);
    irq_chk = 1'b1;
  endtask

  task automatic rd(input logic [15:0] ofs, input logic [15:0] exp, input string name);
    port_id     = BASE + ofs;
    read_strobe = 1'b1;
    rd_exp_q.push_back(exp);
    rd_nm_q.push_back(name);
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic wr(input logic [15:0] ofs, input logic [15:0] data);
    port_id      = BASE + ofs;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] s);
    src_i = s;
    tick();
    src_i = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;

    exp_irq(1'b0, "reset_irq");
    rd(16'd1, 16'h000F, "reset_mask");
    rd(16'd0, 16'h0000, "reset_status");
    rd(16'd3, 16'h0000, "reset_vector");

    pulse(4'b0100);
    exp_irq(1'b1, "src2_irq");
    rd(16'd0, 16'h0004, "src2_status");
    ack();
    exp_irq(1'b0, "src2_ack_irq");
    rd(16'd3, 16'h8002, "src2_vector");
    rd(16'd0, 16'h0000, "src2_ack_status");

    pulse(4'b1010);
    exp_irq(1'b1, "dual_irq");
    ack();
    rd(16'd3, 16'h8001, "dual_vector1");
    exp_irq(1'b1, "dual_irq_mid");
    ack();
    exp_irq(1'b0, "dual_irq_end");
    rd(16'd3, 16'h8003, "dual_vector2");

    wr(16'd1, 16'h0000);
    pulse(4'b0001);
    exp_irq(1'b0, "masked_irq");
    rd(16'd0, 16'h0001, "masked_status");
    ack();
    rd(16'd3, 16'h0000, "masked_ack_vector");
    rd(16'd0, 16'h0001, "masked_ack_status");
    wr(16'd1, 16'h0001);
    exp_irq(1'b1, "unmask_irq");
    rd(16'd1, 16'h0001, "unmask_mask");
    ack();
    rd(16'd3, 16'h8000, "unmask_vector");
    wr(16'd1, 16'hFFFF);
    rd(16'd1, 16'h000F, "mask_upper_bits");
    rd(16'd5, 16'h0000, "undecoded_read");
    rd(16'd2, 16'h0000, "clear_reads_zero");

    pulse(4'b0001);
    pulse(4'b0001);
    rd(16'd4, 16'h0001, "overrun_set");
    wr(16'd2, 16'h0001);
    exp_irq(1'b0, "clear_irq");
    rd(16'd0, 16'h0000, "clear_status");
    rd(16'd4, 16'h0000, "clear_overrun");

    pulse(4'b0001);
    src_i = 4'b0001;
    wr(16'd2, 16'h0001);
    src_i = '0;
    rd(16'd0, 16'h0001, "set_beats_clear_status");
    rd(16'd4, 16'h0000, "set_beats_clear_overrun");
    src_i = 4'b0001;
    ack();
    src_i = '0;
    rd(16'd3, 16'h8000, "set_beats_ack_vector");
    rd(16'd0, 16'h0001, "set_beats_ack_status");
    rd(16'd4, 16'h0000, "set_beats_ack_overrun");
    wr(16'd2, 16'h000F);

    pulse(4'b1000);
    #1;
    reset = 1'b1;
    exp_irq(1'b0, "async_reset_irq");
    tick();
    reset = 1'b0;
    ack();
    rd(16'd3, 16'h0000, "post_reset_vector");
    rd(16'd0, 16'h0000, "post_reset_status");

    src_i = 4'b1000;
    repeat (10) tick();
    src_i = '0;
    tick();
`ifdef INTC_EDGE_DETECT_EN
    rd(16'd4, 16'h0000, "level_overrun");
    ack();
    rd(16'd0, 16'h0000, "level_status_after_ack");
`else
    rd(16'd4, 16'h0008, "level_overrun");
    rd(16'd0, 16'h0008, "level_status");
`endif

    done = 1'b1;
    tick();
    tick();
    $display("FAIL summary_not_reached: got hang want finish");
    $fatal(1, "monitor did not finish");
  end

endmodule
